// File: rtl/trig_conditioner.sv
// Trigger conditioner: synchronizes the raw envelope comparator, debounces it into a
// gap-bridged packet trigger and measures packet length. Optional stats: TRIG_CONDITIONER_STATS_EN.
module trig_conditioner #(
  parameter int unsigned RISE_CYCLES    = 8,
  parameter int unsigned FALL_CYCLES    = 25,
  parameter int unsigned MIN_PKT_CYCLES = 1000,
  parameter int unsigned HOLDOFF_CYCLES = 50,
  parameter int unsigned LEN_WIDTH      = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 raw_trig,
  output logic                 trig,
  output logic                 trig_rise,
  output logic                 trig_fall,
  output logic [LEN_WIDTH-1:0] pkt_len,
  output logic                 pkt_len_valid,
  output logic                 runt,
  output logic                 busy
`ifdef TRIG_CONDITIONER_STATS_EN
  ,
  output logic [15:0]          glitch_cnt,
  output logic [15:0]          runt_cnt,
  output logic [15:0]          pkt_cnt
`endif
);

  localparam int unsigned CNT_MAX0 = (RISE_CYCLES > FALL_CYCLES) ? RISE_CYCLES : FALL_CYCLES;
  localparam int unsigned CNT_MAX  = (CNT_MAX0 > HOLDOFF_CYCLES) ? CNT_MAX0 : HOLDOFF_CYCLES;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMING    = 3'd1,
    ST_ACTIVE    = 3'd2,
    ST_RELEASING = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] len_inc;
  logic [LEN_WIDTH-1:0] pkt_len_q, pkt_len_d;
  logic                 sync1_q, s_q;
  logic                 trig_q, trig_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic                 valid_q, valid_d;
  logic                 runt_q, runt_d;
  logic                 busy_q, busy_d;

  // Two-flop synchronizer for the asynchronous comparator output
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      sync1_q <= raw_trig;
      s_q     <= sync1_q;
    end
  end

  assign len_inc = (len_q == {LEN_WIDTH{1'b1}}) ? len_q : len_q + LEN_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      pkt_len_q <= '0;
      trig_q    <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      valid_q   <= 1'b0;
      runt_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      pkt_len_q <= pkt_len_d;
      trig_q    <= trig_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      valid_q   <= valid_d;
      runt_q    <= runt_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    pkt_len_d = pkt_len_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    valid_d   = 1'b0;
    runt_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        len_d = '0;
        if (s_q) begin
          state_d = ST_ARMING;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_ARMING: begin
        if (!s_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(RISE_CYCLES)) begin
          // len already covers every high sample seen since IDLE, so pkt_len equals raw high time
          state_d = ST_ACTIVE;
          rise_d  = 1'b1;
          cnt_d   = '0;
          len_d   = LEN_WIDTH'(RISE_CYCLES + 1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACTIVE: begin
        len_d = len_inc;
        if (!s_q) begin
          state_d = ST_RELEASING;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_RELEASING: begin
        len_d = len_inc;
        if (s_q) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(FALL_CYCLES)) begin
          state_d = ST_HOLDOFF;
          cnt_d   = '0;
          fall_d  = 1'b1;
          if (len_q == {LEN_WIDTH{1'b1}}) begin
            pkt_len_d = {LEN_WIDTH{1'b1}};
            valid_d   = 1'b1;
          end else begin
            pkt_len_d = len_q - LEN_WIDTH'(FALL_CYCLES);
            valid_d   = (pkt_len_d >= LEN_WIDTH'(MIN_PKT_CYCLES));
            runt_d    = !valid_d;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q == CNT_W'(HOLDOFF_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        len_d   = '0;
      end
    endcase

    // Disable wins over everything and abandons any packet in flight without reporting it
    if (!enable) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      len_d     = '0;
      pkt_len_d = pkt_len_q;
      rise_d    = 1'b0;
      fall_d    = 1'b0;
      valid_d   = 1'b0;
      runt_d    = 1'b0;
    end

    trig_d = (state_d == ST_ACTIVE) || (state_d == ST_RELEASING);
    busy_d = (state_d != ST_IDLE);
  end

  assign trig          = trig_q;
  assign trig_rise     = rise_q;
  assign trig_fall     = fall_q;
  assign pkt_len       = pkt_len_q;
  assign pkt_len_valid = valid_q;
  assign runt          = runt_q;
  assign busy          = busy_q;

`ifdef TRIG_CONDITIONER_STATS_EN
  logic        reject_c;
  logic [15:0] glitch_cnt_q, runt_cnt_q, pkt_cnt_q;

  assign reject_c = enable && (state_q == ST_ARMING) && !s_q;

  // Saturating event counters; cleared by reset only
  always_ff @(posedge clk) begin
    if (reset) begin
      glitch_cnt_q <= '0;
      runt_cnt_q   <= '0;
      pkt_cnt_q    <= '0;
    end else begin
      if (reject_c && (glitch_cnt_q != 16'hFFFF)) glitch_cnt_q <= glitch_cnt_q + 16'd1;
      if (runt_d && (runt_cnt_q != 16'hFFFF))     runt_cnt_q   <= runt_cnt_q + 16'd1;
      if (valid_d && (pkt_cnt_q != 16'hFFFF))     pkt_cnt_q    <= pkt_cnt_q + 16'd1;
    end
  end

  assign glitch_cnt = glitch_cnt_q;
  assign runt_cnt   = runt_cnt_q;
  assign pkt_cnt    = pkt_cnt_q;
`endif

endmodule
